alu_share_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational `alu`. It accepts operations over valid/ready request ports and grants one at a time. It drives the `alu` with registered operands, captures `alu_output` into a result register, and returns the result on the granting requester's response port. It sits between the decode/execute front ends and the single `alu` instance in the rv32i datapath.

---
 rtl/alu_share_arb.sv | 149 ++++++++++++++
 tb/tb_alu_share_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Two-requester arbiter and sequencer in front of the single shared
//   combinational alu. One operation is granted at a time over valid/ready
//   request ports. Its operands are registered and drive the alu directly,
//   the alu output is captured into a result register, and the result is
//   returned on the granted requester's response port.
//
//   Configuration macro: ALU_SHARE_RR_EN
//     defined   : round-robin between requesters when both are valid
//     undefined : fixed priority, requester 0 wins when both are valid
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for requester N (0/1)
//   reqN_sel, reqN_a, reqN_b     alu opcode and operands
//   rspN_valid / rspN_ready      response handshake for requester N
//   rspN_data                    result (mirrors the result register)
//   alu_sel, alu_input_A/B       registered operation driven to the alu
//   alu_output                   combinational result from the alu
//   busy                         high whenever an operation is in flight
module alu_share_arb #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_sel,
  input  logic [DWIDTH-1:0] req0_a,
  input  logic [DWIDTH-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_sel,
  input  logic [DWIDTH-1:0] req1_a,
  input  logic [DWIDTH-1:0] req1_b,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_data,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [3:0]        alu_sel,
  output logic [DWIDTH-1:0] alu_input_A,
  output logic [DWIDTH-1:0] alu_input_B,
  input  logic [DWIDTH-1:0] alu_output,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        op_sel;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic [DWIDTH-1:0] result;
  logic              owner;
  logic              last_grant;
  logic              pick0;
  logic              acc0;
  logic              acc1;

  // pick0: requester 0 wins a simultaneous request.
`ifdef ALU_SHARE_RR_EN
  // Round-robin: requester 0 wins when requester 1 was the last one served.
  assign pick0 = last_grant;
`else
  // Fixed priority: last_grant is still tracked but never changes the winner.
  assign pick0 = 1'b1 | last_grant;
`endif

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & (~req1_valid | pick0);
        req1_ready = req1_valid & ~(req0_valid & pick0);
        if (req0_ready || req1_ready) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accept stage: operands latched on the handshake edge; EXEC stage: the
  // alu settles on the latched operands and its output is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_sel     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (acc0) begin
        op_sel     <= req0_sel;
        op_a       <= req0_a;
        op_b       <= req0_b;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (acc1) begin
        op_sel     <= req1_sel;
        op_a       <= req1_a;
        op_b       <= req1_b;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == EXEC) begin
        result <= alu_output;
      end
    end
  end

  // Response stage: everything below is driven from registers only.
  assign alu_sel     = op_sel;
  assign alu_input_A = op_a;
  assign alu_input_B = op_b;
  assign rsp0_data   = result;
  assign rsp1_data   = result;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  localparam int DW = 32;

`ifdef ALU_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_sel, req1_sel;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_input_A, alu_input_B, alu_output;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the team alu: sel 0 = add, a few others, anything for unused codes.
  function automatic logic [31:0] tb_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      default: return a ^ {b[27:0], s};
    endcase
  endfunction

  assign alu_output = tb_alu(alu_sel, alu_input_A, alu_input_B);

  alu_share_arb #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .alu_sel(alu_sel), .alu_input_A(alu_input_A), .alu_input_B(alu_input_B),
    .alu_output(alu_output), .busy(busy)
  );

  // Reference model: an operation is tracked by its age in cycles since it
  // was accepted (-1 = nothing in flight). Age 1 is the evaluate cycle, age 2+
  // is the response phase that lasts until the owner's rsp_ready.
  int          m_age = -1;
  logic        m_owner = 1'b0;
  logic        m_last = 1'b1;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        mg0, mg1;

  always_comb begin
    mg0 = 1'b0;
    mg1 = 1'b0;
    if (m_age < 0) begin
      if (req0_valid && req1_valid) begin
        if (RR && m_last == 1'b0) mg1 = 1'b1;
        else                      mg0 = 1'b1;
      end else if (req0_valid) begin
        mg0 = 1'b1;
      end else if (req1_valid) begin
        mg1 = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_age <= -1; m_owner <= 1'b0; m_last <= 1'b1;
      m_sel <= '0; m_a <= '0; m_b <= '0; m_res <= '0;
    end else if (m_age < 0) begin
      if (mg0) begin
        m_sel <= req0_sel; m_a <= req0_a; m_b <= req0_b;
        m_owner <= 1'b0; m_last <= 1'b0; m_age <= 1;
      end else if (mg1) begin
        m_sel <= req1_sel; m_a <= req1_a; m_b <= req1_b;
        m_owner <= 1'b1; m_last <= 1'b1; m_age <= 1;
      end
    end else if (m_age == 1) begin
      m_res <= tb_alu(m_sel, m_a, m_b);
      m_age <= 2;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_age <= -1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, mg0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, mg1});
    chk("busy",       {31'b0, busy},       {31'b0, m_age >= 1});
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, (m_age >= 2) && !m_owner});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, (m_age >= 2) && m_owner});
    chk("rsp0_data",  rsp0_data,  m_res);
    chk("rsp1_data",  rsp1_data,  m_res);
    chk("alu_sel",    {28'b0, alu_sel}, {28'b0, m_sel});
    chk("alu_input_A", alu_input_A, m_a);
    chk("alu_input_B", alu_input_B, m_b);
  endtask

  typedef struct {
    logic        v0, v1;
    logic [3:0]  s0, s1;
    logic [31:0] a0, b0, a1, b1;
    logic        rr0, rr1;
    logic        e_rdy0, e_rdy1, e_busy, e_rv0, e_rv1;
    logic [31:0] e_data, e_alua;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic rr0, input logic rr1,
                              input logic e_rdy0, input logic e_rdy1, input logic e_busy,
                              input logic e_rv0, input logic e_rv1,
                              input logic [31:0] e_data, input logic [31:0] e_alua);
    vec_t v;
    v.v0 = v0; v.s0 = s0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.s1 = s1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_busy = e_busy;
    v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_data = e_data; v.e_alua = e_alua;
    return v;
  endfunction

  // Check point is the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic step_tab(input int idx, input vec_t v);
    @(negedge clk);
    check_model();
    chk($sformatf("tab%0d_rdy0", idx), {31'b0, req0_ready}, {31'b0, v.e_rdy0});
    chk($sformatf("tab%0d_rdy1", idx), {31'b0, req1_ready}, {31'b0, v.e_rdy1});
    chk($sformatf("tab%0d_busy", idx), {31'b0, busy},       {31'b0, v.e_busy});
    chk($sformatf("tab%0d_rv0", idx),  {31'b0, rsp0_valid}, {31'b0, v.e_rv0});
    chk($sformatf("tab%0d_rv1", idx),  {31'b0, rsp1_valid}, {31'b0, v.e_rv1});
    chk($sformatf("tab%0d_data", idx), v.e_rv1 ? rsp1_data : rsp0_data, v.e_data);
    chk($sformatf("tab%0d_aluA", idx), alu_input_A, v.e_alua);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_sel = '0; req1_sel = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  vec_t tab[10];

  initial begin
    //            v0 s0 a0  b0  v1 s1 a1 b1 rr0 rr1  rdy0 rdy1 busy rv0 rv1 data alua
    tab[0] = mk(1, 0, 10, 10, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 0,  0);
    tab[1] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 0, 0,  10);
    tab[2] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 20, 10);
    tab[3] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 20, 10);
    tab[4] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 1, 1, 0, 20, 10);
    tab[5] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 20, 10);
    tab[6] = mk(0, 0, 0,  0,  1, 1, 9, 4, 1, 1,   0, 1, 0, 0, 0, 20, 10);
    tab[7] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 0, 20, 9);
    tab[8] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1, 5,  9);
    tab[9] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 5,  9);

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Directed table: single requests on each port, with response backpressure.
    for (int i = 0; i < 10; i++) begin
      req0_valid = tab[i].v0; req0_sel = tab[i].s0; req0_a = tab[i].a0; req0_b = tab[i].b0;
      req1_valid = tab[i].v1; req1_sel = tab[i].s1; req1_a = tab[i].a1; req1_b = tab[i].b1;
      rsp0_ready = tab[i].rr0; rsp1_ready = tab[i].rr1;
      step_tab(i, tab[i]);
    end

    // Backpressure on requester 1 while requester 0 keeps asking.
    idle_inputs();
    rst = 1'b1; step(); rst = 1'b0;
    req1_valid = 1'b1; req1_sel = 4'd0; req1_a = 32'd100; req1_b = 32'd23; rsp1_ready = 1'b0;
    step();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    step();
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_data", rsp1_data, 32'd123);
      chk("bp_busy", {31'b0, busy}, 32'd1);
      chk("bp_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    #2;
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    step();

    // Reset while the operation is being evaluated.
    idle_inputs();
    rst = 1'b1; step(); rst = 1'b0;
    req0_valid = 1'b1; req0_sel = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
    step();
    req0_valid = 1'b0; rst = 1'b1;
    #2;
    chk("rx_exec_busy", {31'b0, busy}, 32'd1);
    step();
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 32'd7;
    #2;
    chk("rx_busy", {31'b0, busy}, 32'd0);
    chk("rx_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rx_alu_a", alu_input_A, 32'd0);
    chk("rx_ready0", {31'b0, req0_ready}, 32'd1);
    chk("rx_ready1", {31'b0, req1_ready}, 32'd0);
    step();

    // Both requesters held valid with responses always consumed.
    for (int i = 0; i < 18; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_sel = 4'($urandom_range(0, 5)); req1_sel = 4'($urandom_range(0, 5));
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();
    end

    // Random traffic, backpressure and occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_sel = 4'($urandom); req1_sel = 4'($urandom);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
